// File: rtl/edfic_hart_if.sv
// Core-side end of the EDF interrupt controller: preemption decision, request/claim
// handshake with the hart, and a nesting stack of absolute handler deadlines.
module edfic_hart_if #(
   parameter  int NrIrqs    = 4,
   parameter  int DlWidth   = 24,
   parameter  int NestDepth = 4,
   localparam int IdWidth   = $clog2(NrIrqs),
   localparam int NestW     = $clog2(NestDepth + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [63:0]        mtime_i,
   input  logic               irq_valid_i,
   input  logic [IdWidth-1:0] irq_id_i,
   input  logic [DlWidth-1:0] irq_dl_i,
   output logic               irq_ack_o,
   output logic [IdWidth-1:0] irq_id_o,
   output logic               core_irq_o,
   output logic [IdWidth-1:0] core_irq_id_o,
   input  logic               core_take_i,
   input  logic               core_exit_i,
   output logic [NestW-1:0]   nest_o,
   output logic [DlWidth-1:0] cur_dl_o,
   output logic               exit_err_o
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [NestW-1:0]     depth_q, depth_d;
   logic [DlWidth-1:0]   cur_abs_q, cur_abs_d;
   logic [DlWidth-1:0]   off_dl_q, off_dl_d;
   logic [IdWidth-1:0]   core_irq_id_q, core_irq_id_d;
   logic [IdWidth-1:0]   irq_id_q, irq_id_d;
   logic                 exit_err_q, exit_err_d;
   logic                 core_irq_q, core_irq_d;
   logic                 irq_ack_q, irq_ack_d;
   logic [DlWidth-1:0]   stack_q [NestDepth];
   logic [DlWidth-1:0]   stack_d [NestDepth];

   logic [DlWidth-1:0]   now;
   logic [DlWidth-1:0]   cur_rel;
   logic [DlWidth-1:0]   pop_val;
   logic                 depth_zero;
   logic                 eligible;
   logic                 push;
   logic                 unused_mtime_hi;

   // Only the low DlWidth bits of mtime take part in the modular deadline arithmetic.
   assign unused_mtime_hi = ^mtime_i[63:DlWidth];

   always_comb begin
      now        = mtime_i[DlWidth-1:0];
      cur_rel    = cur_abs_q - now;
      depth_zero = (depth_q == '0);
      eligible   = irq_valid_i && (depth_q < NestW'(NestDepth)) &&
                   (depth_zero || (irq_dl_i < cur_rel));
   end

   // Entry (depth-2) holds the deadline of the handler that resumes on exit.
   always_comb begin
      pop_val = '0;
      for (int i = 0; i < NestDepth; i++) begin
         if (depth_q == NestW'(i + 2)) pop_val = stack_q[i];
      end
   end

   always_comb begin
      state_d       = state_q;
      depth_d       = depth_q;
      cur_abs_d     = cur_abs_q;
      off_dl_d      = off_dl_q;
      core_irq_id_d = core_irq_id_q;
      irq_id_d      = irq_id_q;
      exit_err_d    = exit_err_q;
      push          = 1'b0;

      if (core_exit_i) begin
         if (depth_zero) begin
            exit_err_d = 1'b1;
         end else begin
            depth_d   = depth_q - NestW'(1);
            cur_abs_d = (depth_q == NestW'(1)) ? '0 : pop_val;
         end
      end

      case (state_q)
         ST_WAIT: begin
            if (eligible) begin
               state_d       = ST_REQ;
               core_irq_id_d = irq_id_i;
               off_dl_d      = irq_dl_i;
            end
         end
         ST_REQ: begin
            // An exit in the same cycle wins over a take: drop back and re-evaluate.
            if (core_exit_i || !eligible) begin
               state_d = ST_WAIT;
            end else if (core_take_i) begin
               state_d   = ST_ACK;
               push      = !depth_zero;
               cur_abs_d = off_dl_q + now;
               depth_d   = depth_q + NestW'(1);
               irq_id_d  = core_irq_id_q;
            end else begin
               core_irq_id_d = irq_id_i;
               off_dl_d      = irq_dl_i;
            end
         end
         ST_ACK: begin
            state_d = ST_WAIT;
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase

      core_irq_d = (state_d == ST_REQ);
      irq_ack_d  = (state_d == ST_ACK);
   end

   for (genvar gi = 0; gi < NestDepth; gi++) begin : g_stack
      assign stack_d[gi] = (push && (depth_q == NestW'(gi + 1))) ? cur_abs_q : stack_q[gi];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_WAIT;
         depth_q       <= '0;
         cur_abs_q     <= '0;
         off_dl_q      <= '0;
         core_irq_id_q <= '0;
         irq_id_q      <= '0;
         exit_err_q    <= 1'b0;
         core_irq_q    <= 1'b0;
         irq_ack_q     <= 1'b0;
         for (int i = 0; i < NestDepth; i++) stack_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         depth_q       <= depth_d;
         cur_abs_q     <= cur_abs_d;
         off_dl_q      <= off_dl_d;
         core_irq_id_q <= core_irq_id_d;
         irq_id_q      <= irq_id_d;
         exit_err_q    <= exit_err_d;
         core_irq_q    <= core_irq_d;
         irq_ack_q     <= irq_ack_d;
         for (int i = 0; i < NestDepth; i++) stack_q[i] <= stack_d[i];
      end
   end

   assign irq_ack_o     = irq_ack_q;
   assign irq_id_o      = irq_id_q;
   assign core_irq_o    = core_irq_q;
   assign core_irq_id_o = core_irq_id_q;
   assign nest_o        = depth_q;
   assign cur_dl_o      = depth_zero ? '0 : cur_rel;
   assign exit_err_o    = exit_err_q;

endmodule

// File: tb/tb_edfic_hart_if.sv
// Directed bench for edfic_hart_if: handshake latency, preemption, nesting stack,
// deadline wrap-around, exit errors and reset in mid-handshake.
module tb_edfic_hart_if;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] mtime;
   logic        valid;
   logic [1:0]  id;
   logic [23:0] dl;
   logic        take;
   logic        ext;
   logic        ack;
   logic [1:0]  ack_id;
   logic        core_irq;
   logic [1:0]  core_id;
   logic [2:0]  nest;
   logic [23:0] cur_dl;
   logic        exit_err;

   int n_checks = 0;
   int n_fail   = 0;

   edfic_hart_if #(.NrIrqs(4), .DlWidth(24), .NestDepth(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mtime_i      (mtime),
      .irq_valid_i  (valid),
      .irq_id_i     (id),
      .irq_dl_i     (dl),
      .irq_ack_o    (ack),
      .irq_id_o     (ack_id),
      .core_irq_o   (core_irq),
      .core_irq_id_o(core_id),
      .core_take_i  (take),
      .core_exit_i  (ext),
      .nest_o       (nest),
      .cur_dl_o     (cur_dl),
      .exit_err_o   (exit_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
         $display("ok   %-18s = %0h", tag, obs);
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; mtime = 64'd1000; valid = 1'b0; id = 2'd0; dl = 24'd0;
      take = 1'b0; ext = 1'b0;
      step(); step();
      check("rst_core_irq", 64'(core_irq), 64'd0);
      check("rst_ack",      64'(ack),      64'd0);
      check("rst_nest",     64'(nest),     64'd0);
      check("rst_cur_dl",   64'(cur_dl),   64'd0);
      check("rst_exit_err", 64'(exit_err), 64'd0);
      check("rst_ack_id",   64'(ack_id),   64'd0);
      rst = 1'b0;

      // Idle offer and take: abs = 1100
      valid = 1'b1; id = 2'd2; dl = 24'd100;
      step();
      check("idle_req",     64'(core_irq), 64'd1);
      check("idle_req_id",  64'(core_id),  64'd2);
      check("idle_no_ack",  64'(ack),      64'd0);
      take = 1'b1;
      step();
      check("idle_ack",     64'(ack),      64'd1);
      check("idle_ack_id",  64'(ack_id),   64'd2);
      check("idle_req_off", 64'(core_irq), 64'd0);
      check("idle_nest",    64'(nest),     64'd1);
      take = 1'b0; valid = 1'b0; mtime = 64'd1010;
      step();
      check("idle_ack_off", 64'(ack),      64'd0);
      check("idle_cur_dl",  64'(cur_dl),   64'd90);

      // Preemption: cur_rel = 1100-1050 = 50
      mtime = 64'd1050; valid = 1'b1; id = 2'd1; dl = 24'd50;
      step();
      check("pre_eq_norq",  64'(core_irq), 64'd0);
      dl = 24'd60;
      step();
      check("pre_gt_norq",  64'(core_irq), 64'd0);
      dl = 24'd40;
      step();
      check("pre_lt_req",   64'(core_irq), 64'd1);
      check("pre_req_id",   64'(core_id),  64'd1);
      take = 1'b1;
      step();
      check("pre_ack",      64'(ack),      64'd1);
      check("pre_ack_id",   64'(ack_id),   64'd1);
      check("pre_nest",     64'(nest),     64'd2);
      take = 1'b0; valid = 1'b0;
      step();
      check("pre_inner_dl", 64'(cur_dl),   64'd40);
      ext = 1'b1; mtime = 64'd1070;
      step();
      ext = 1'b0;
      check("pre_pop_nest", 64'(nest),     64'd1);
      check("pre_outer_dl", 64'(cur_dl),   64'd30);

      // Track a better winner, then retract: cur_rel = 1100-1070 = 30
      valid = 1'b1; id = 2'd1; dl = 24'd25;
      step();
      check("trk_req",      64'(core_irq), 64'd1);
      check("trk_id1",      64'(core_id),  64'd1);
      id = 2'd3; dl = 24'd20;
      step();
      check("trk_id3",      64'(core_id),  64'd3);
      valid = 1'b0;
      step();
      check("ret_req_off",  64'(core_irq), 64'd0);
      check("ret_no_ack",   64'(ack),      64'd0);
      step();
      check("ret_no_ack2",  64'(ack),      64'd0);
      ext = 1'b1;
      step();
      ext = 1'b0;
      check("ret_nest0",    64'(nest),     64'd0);
      check("ret_cur_dl0",  64'(cur_dl),   64'd0);

      // Fill the stack: abs 2080, 2060, 2040, 2020
      mtime = 64'd2000;
      valid = 1'b1; id = 2'd0; dl = 24'd80; step(); take = 1'b1; step(); take = 1'b0; valid = 1'b0; step();
      valid = 1'b1; id = 2'd1; dl = 24'd60; step(); take = 1'b1; step(); take = 1'b0; valid = 1'b0; step();
      valid = 1'b1; id = 2'd2; dl = 24'd40; step(); take = 1'b1; step(); take = 1'b0; valid = 1'b0; step();
      valid = 1'b1; id = 2'd3; dl = 24'd20; step(); take = 1'b1; step(); take = 1'b0; valid = 1'b0; step();
      check("full_nest",    64'(nest),     64'd4);
      check("full_cur_dl",  64'(cur_dl),   64'd20);
      valid = 1'b1; id = 2'd1; dl = 24'd1;
      step();
      check("full_norq",    64'(core_irq), 64'd0);
      step();
      check("full_norq2",   64'(core_irq), 64'd0);
      ext = 1'b1;
      step();
      ext = 1'b0;
      check("full_pop_nest", 64'(nest),    64'd3);
      check("full_pop_dl",  64'(cur_dl),   64'd40);
      step();
      check("full_req",     64'(core_irq), 64'd1);
      valid = 1'b0;
      step();
      ext = 1'b1;
      step();
      check("full_pop2_dl", 64'(cur_dl),   64'd60);
      step();
      check("full_pop3_dl", 64'(cur_dl),   64'd80);
      step();
      ext = 1'b0;
      check("full_empty",   64'(nest),     64'd0);

      // Wrap-around: now = 0xFFFFF6 (upper mtime bits nonzero), abs = 20
      mtime = 64'h0000_0005_00FF_FFF6;
      valid = 1'b1; id = 2'd2; dl = 24'd30;
      step(); take = 1'b1; step(); take = 1'b0; valid = 1'b0; step();
      check("wrap_nest",    64'(nest),     64'd1);
      check("wrap_cur_dl",  64'(cur_dl),   64'd30);
      valid = 1'b1; id = 2'd0; dl = 24'd25;
      step();
      check("wrap_preempt", 64'(core_irq), 64'd1);
      take = 1'b1;
      step();
      check("wrap_ack_id",  64'(ack_id),   64'd0);
      take = 1'b0; valid = 1'b0;
      step();
      check("wrap_in_dl",   64'(cur_dl),   64'd25);
      ext = 1'b1;
      step();
      check("wrap_out_dl",  64'(cur_dl),   64'd30);
      step();
      ext = 1'b0;

      // Exit at depth 0 is sticky
      check("err_clear",    64'(exit_err), 64'd0);
      ext = 1'b1;
      step();
      ext = 1'b0;
      check("err_set",      64'(exit_err), 64'd1);
      check("err_nest",     64'(nest),     64'd0);
      step();
      check("err_sticky",   64'(exit_err), 64'd1);

      // Exit and take in the same REQ cycle: no ack, re-offer next
      valid = 1'b1; id = 2'd1; dl = 24'd10;
      step();
      check("xt_req",       64'(core_irq), 64'd1);
      ext = 1'b1; take = 1'b1;
      step();
      ext = 1'b0; take = 1'b0;
      check("xt_no_ack",    64'(ack),      64'd0);
      check("xt_wait",      64'(core_irq), 64'd0);
      check("xt_nest",      64'(nest),     64'd0);
      step();
      check("xt_reoffer",   64'(core_irq), 64'd1);
      take = 1'b1;
      step();
      check("xt_ack",       64'(ack),      64'd1);
      take = 1'b0; valid = 1'b0;
      step();

      // Reset while in ACK (cur_rel = 10, offer 5)
      valid = 1'b1; id = 2'd3; dl = 24'd5;
      step(); take = 1'b1; step();
      check("rack_ack",     64'(ack),      64'd1);
      check("rack_nest",    64'(nest),     64'd2);
      rst = 1'b1; take = 1'b0; valid = 1'b0;
      step();
      check("rack_ack0",    64'(ack),      64'd0);
      check("rack_irq0",    64'(core_irq), 64'd0);
      check("rack_nest0",   64'(nest),     64'd0);
      check("rack_dl0",     64'(cur_dl),   64'd0);
      check("rack_err0",    64'(exit_err), 64'd0);
      check("rack_id0",     64'(ack_id),   64'd0);
      rst = 1'b0;
      step();
      check("rack_post",    64'(ack),      64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
